// File: rtl/led_divider_bank.sv
// Bank of independent LED divider channels. Each channel counts enabled clocks
// over a period of P+1 and drives its LED in one of four modes:
// off, toggle (square wave), pulse (one clock per period), or PWM.
module led_divider_bank #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [CHANNELS-1:0] enable_i,
  input  logic                load_i,
  input  logic [IDX_W-1:0]    load_ch_i,
  input  logic [CNT_W-1:0]    load_period_i,
  input  logic [CNT_W-1:0]    load_duty_i,
  input  logic [1:0]          load_mode_i,
  output logic [CHANNELS-1:0] out_o,
  output logic [CHANNELS-1:0] tick_o
);

  typedef enum logic [1:0] {
    ModeOff    = 2'd0,
    ModeToggle = 2'd1,
    ModePulse  = 2'd2,
    ModePwm    = 2'd3
  } mode_e;

  logic [CNT_W-1:0]    period_q [CHANNELS];
  logic [CNT_W-1:0]    period_d [CHANNELS];
  logic [CNT_W-1:0]    duty_q   [CHANNELS];
  logic [CNT_W-1:0]    duty_d   [CHANNELS];
  logic [CNT_W-1:0]    cnt_q    [CHANNELS];
  logic [CNT_W-1:0]    cnt_d    [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt  [CHANNELS];
  mode_e               mode_q   [CHANNELS];
  mode_e               mode_d   [CHANNELS];
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] load_sel, active, term;

  // Next-state for every channel: load wins over counting, OFF forces idle.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      mode_d[i]   = mode_q[i];
      cnt_d[i]    = cnt_q[i];
      out_d[i]    = out_q[i];
      tick_d[i]   = 1'b0;

      // Out-of-range indices never match any channel, so they are ignored.
      load_sel[i] = load_i && (int'(load_ch_i) == i);
      active[i]   = enable_i[i] && (mode_q[i] != ModeOff);
      term[i]     = active[i] && (cnt_q[i] == period_q[i]);
      cnt_nxt[i]  = term[i] ? '0 : cnt_q[i] + CNT_W'(1);

      if (load_sel[i]) begin
        period_d[i] = load_period_i;
        duty_d[i]   = load_duty_i;
        mode_d[i]   = mode_e'(load_mode_i);
        cnt_d[i]    = '0;
        out_d[i]    = 1'b0;
      end else if (mode_q[i] == ModeOff) begin
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
      end else if (active[i]) begin
        cnt_d[i]  = cnt_nxt[i];
        tick_d[i] = term[i];
        case (mode_q[i])
          ModeToggle: out_d[i] = out_q[i] ^ term[i];
          ModePulse:  out_d[i] = term[i];
          ModePwm:    out_d[i] = (cnt_nxt[i] < duty_q[i]);
          default:    out_d[i] = 1'b0;
        endcase
      end else if (mode_q[i] == ModePulse) begin
        // Pulse output mirrors tick, which is low while disabled.
        out_d[i] = 1'b0;
      end
    end
  end

  // Channel state registers with synchronous reset to OFF.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        mode_q[i]   <= ModeOff;
        cnt_q[i]    <= '0;
      end
      out_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        period_q[i] <= period_d[i];
        duty_q[i]   <= duty_d[i];
        mode_q[i]   <= mode_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign out_o  = out_q;
  assign tick_o = tick_q;

endmodule

// File: tb/tb_led_divider_bank.sv
// Directed bench for led_divider_bank: toggle, PWM, pulse, enable freeze,
// load-vs-terminal priority, invalid load index and reset abort.
module tb_led_divider_bank;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned CNT_W    = 26;
  localparam int unsigned IDX_W    = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [CHANNELS-1:0] enable;
  logic                load;
  logic [IDX_W-1:0]    load_ch;
  logic [CNT_W-1:0]    load_period;
  logic [CNT_W-1:0]    load_duty;
  logic [1:0]          load_mode;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] tick;

  int n_assert = 0;
  int n_fail   = 0;

  led_divider_bank #(
    .CHANNELS(CHANNELS),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) dut (
    .clock_i      (clk),
    .reset_i      (reset),
    .enable_i     (enable),
    .load_i       (load),
    .load_ch_i    (load_ch),
    .load_period_i(load_period),
    .load_duty_i  (load_duty),
    .load_mode_i  (load_mode),
    .out_o        (out),
    .tick_o       (tick)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic do_load(input int ch, input int p, input int d, input int m);
    load        = 1'b1;
    load_ch     = IDX_W'(ch);
    load_period = CNT_W'(p);
    load_duty   = CNT_W'(d);
    load_mode   = 2'(m);
    step();
    load        = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = '0;
    load        = 1'b0;
    load_ch     = '0;
    load_period = '0;
    load_duty   = '0;
    load_mode   = 2'd0;

    // Reset state
    do_reset();
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);

    // Toggle ch0, P=3: out toggles and tick pulses every 4 clocks
    enable = 4'b0001;
    do_load(0, 3, 0, 1);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("t1_out k=%0d", k), 32'(out), 32'((k / 4) % 2));
      chk($sformatf("t1_tick k=%0d", k), 32'(tick), 32'((k % 4) == 0));
    end

    // PWM ch1, P=9 D=3: high 3, low 7
    do_reset();
    enable = 4'b1111;
    do_load(1, 9, 3, 3);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("t2_out k=%0d", k), 32'(out), 32'(((k % 10) < 3) ? 4'b0010 : 4'b0000));
      chk($sformatf("t2_tick k=%0d", k), 32'(tick), 32'(((k % 10) == 0) ? 4'b0010 : 4'b0000));
    end
    do_load(1, 9, 0, 3);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("t2_d0 k=%0d", k), 32'(out[1]), 32'h0);
    end
    do_load(1, 9, 12, 3);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("t2_d12 k=%0d", k), 32'(out[1]), 32'h1);
    end

    // Pulse ch2, P=0: out=tick=1 every enabled cycle
    do_reset();
    enable = 4'b1111;
    do_load(2, 0, 0, 2);
    chk("t3_load_out", 32'(out), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t3_out k=%0d", k), 32'(out), 32'h4);
      chk($sformatf("t3_tick k=%0d", k), 32'(tick), 32'h4);
    end
    enable = 4'b1011;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("t3_dis_out k=%0d", k), 32'(out), 32'h0);
      chk($sformatf("t3_dis_tick k=%0d", k), 32'(tick), 32'h0);
    end
    enable = 4'b1111;
    step();
    chk("t3_resume_out", 32'(out), 32'h4);
    chk("t3_resume_tick", 32'(tick), 32'h4);

    // Toggle ch0 P=5, freeze at cnt=2 for 7 clocks after first toggle
    do_reset();
    enable = 4'b0001;
    do_load(0, 5, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("t4_out k=%0d", k), 32'(out), 32'(k >= 6));
      chk($sformatf("t4_tick k=%0d", k), 32'(tick), 32'(k == 6));
    end
    enable = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("t4_frz_out k=%0d", k), 32'(out), 32'h1);
      chk($sformatf("t4_frz_tick k=%0d", k), 32'(tick), 32'h0);
    end
    enable = 4'b0001;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk($sformatf("t4_res_out j=%0d", j), 32'(out), 32'(j < 4));
      chk($sformatf("t4_res_tick j=%0d", j), 32'(tick), 32'(j == 4));
    end

    // Load ch3 on its terminal cycle; then an out-of-range load index
    do_reset();
    enable = 4'b1000;
    do_load(3, 3, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("t5_pre_out k=%0d", k), 32'(out), 32'h0);
    end
    do_load(3, 3, 0, 1);
    chk("t5_prio_out", 32'(out), 32'h0);
    chk("t5_prio_tick", 32'(tick), 32'h0);
    for (int k = 5; k <= 8; k++) begin
      step();
      chk($sformatf("t5_out k=%0d", k), 32'(out), 32'((k == 8) ? 4'b1000 : 4'b0000));
      chk($sformatf("t5_tick k=%0d", k), 32'(tick), 32'((k == 8) ? 4'b1000 : 4'b0000));
    end
    enable = 4'b1111;
    do_load(5, 0, 0, 2);
    chk("t5_bad_out k=9", 32'(out), 32'h8);
    chk("t5_bad_tick k=9", 32'(tick), 32'h0);
    for (int k = 10; k <= 12; k++) begin
      step();
      chk($sformatf("t5_bad_out k=%0d", k), 32'(out), 32'((k == 12) ? 4'b0000 : 4'b1000));
      chk($sformatf("t5_bad_tick k=%0d", k), 32'(tick), 32'((k == 12) ? 4'b1000 : 4'b0000));
    end

    // Reset mid-run with PWM and toggle active; reset beats a concurrent load
    do_reset();
    enable = 4'b1111;
    do_load(1, 9, 3, 3);
    do_load(0, 3, 0, 1);
    chk("t6_run_out", 32'(out), 32'h2);
    for (int k = 1; k <= 4; k++) step();
    chk("t6_pre_out", 32'(out), 32'h1);
    chk("t6_pre_tick", 32'(tick), 32'h1);
    reset       = 1'b1;
    load        = 1'b1;
    load_ch     = 3'd2;
    load_period = '0;
    load_mode   = 2'd2;
    step();
    reset = 1'b0;
    load  = 1'b0;
    chk("t6_rst_out", 32'(out), 32'h0);
    chk("t6_rst_tick", 32'(tick), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("t6_off_out k=%0d", k), 32'(out), 32'h0);
      chk($sformatf("t6_off_tick k=%0d", k), 32'(tick), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_divider_bank.md
LED_DIVIDER_BANK -- requirements
Module: led_divider_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 26: width of each channel's period counter, period and duty.
REQ-003 Parameter IDX_W, default 2: width of load_ch; SHALL satisfy 2**IDX_W >= CHANNELS.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  CHANNELS  per-channel count enable; bit i gates channel i.
REQ-007 load  input  1  one-cycle strobe that writes configuration to channel load_ch.
REQ-008 load_ch  input  IDX_W  target channel index for load.
REQ-009 load_period  input  CNT_W  period value P; the channel cycle length is P+1 enabled clocks.
REQ-010 load_duty  input  CNT_W  PWM high-time D in enabled clocks.
REQ-011 load_mode  input  2  0=OFF, 1=TOGGLE, 2=PULSE, 3=PWM.
REQ-012 out  output  CHANNELS  registered per-channel LED drive.
REQ-013 tick  output  CHANNELS  registered one-cycle pulse marking each channel's terminal count.

Function
REQ-014 Each channel SHALL hold registers period, duty, mode, cnt (CNT_W bits) and out/tick bits.
REQ-015 Terminal event for channel i: enable[i]=1, mode!=OFF and cnt==period; cnt SHALL then return to 0, otherwise cnt SHALL increment by 1 while enable[i]=1 and mode!=OFF.
REQ-016 enable[i]=0: cnt, out[i] SHALL hold; tick[i] SHALL be 0.
REQ-017 tick[i] SHALL be 1 in exactly the cycle after a terminal event, 0 otherwise.
REQ-018 OFF: cnt SHALL be held at 0; out[i]=0, tick[i]=0.
REQ-019 TOGGLE: out[i] SHALL invert on each terminal event (square wave, period 2*(P+1) clocks).
REQ-020 PULSE: out[i] SHALL equal tick[i] (one-clock high every P+1 clocks).
REQ-021 PWM: out[i] SHALL be registered as 1 when the next cnt value < duty, else 0; D=0 gives constant 0; D>P gives constant 1.
REQ-022 P=0: every enabled cycle is a terminal event; TOGGLE inverts every cycle, PULSE holds out/tick at 1.
REQ-023 load=1 with load_ch<CHANNELS: next edge SHALL write period, duty, mode and clear that channel's cnt, out and tick; the channel counts from 0 on the following edge.
REQ-024 load=1 with load_ch>=CHANNELS SHALL be ignored; no channel state changes.
REQ-025 A load SHALL take priority over a terminal event on the same channel in the same cycle; other channels SHALL be unaffected.
REQ-026 Counter arithmetic SHALL be CNT_W-bit unsigned; cnt never exceeds period, so no wrap past 2**CNT_W-1 occurs.
REQ-027 Latency: out/tick SHALL change on the same edge that registers the terminal event; no further pipeline stage.

Reset
REQ-028 reset=1 SHALL take priority over load and enable.
REQ-029 On reset every channel SHALL set period=0, duty=0, mode=OFF, cnt=0, out=0, tick=0.
REQ-030 Reset asserted mid-period SHALL abort counting; after release channels stay OFF until loaded.

Verification
REQ-031 Reset, load ch0 P=3 mode=TOGGLE, enable=4'b0001 -> out[0] toggles every 4 clocks, tick[0] pulses every 4 clocks, out[3:1]=0.
REQ-032 Load ch1 P=9 D=3 mode=PWM, enable all -> out[1] high 3 clocks, low 7, repeating; D=0 -> always 0; D=12 -> always 1.
REQ-033 Load ch2 P=0 mode=PULSE -> out[2]=tick[2]=1 every enabled cycle; deassert enable[2] -> both 0, cnt holds.
REQ-034 ch0 TOGGLE P=5 running; drop enable[0] for 7 clocks at cnt=2 -> out[0] and cnt frozen, resume completes remaining 3 counts.
REQ-035 Load ch3 in the cycle cnt==P, plus load_ch=5 with CHANNELS=4 -> ch3 restarts from 0 with out=0, no toggle; invalid load changes nothing.
REQ-036 Assert reset for 1 clock during active PWM and TOGGLE -> all out/tick 0 next cycle, channels remain OFF with enable high.
